// File: rtl/fsm_mealy_pkg.sv
// -----------------------------------------------------------------------------
// fsm_mealy_pkg
// Shared constants for the fsm_mealy 1-0-0-1 serial pattern detector: the
// state register width and the fixed state encodings. The testbench imports
// this package to decode the debug state output y.
// -----------------------------------------------------------------------------
package fsm_mealy_pkg;

  localparam int STATE_W = 3;

  // State encodings; codes 3'b100..3'b111 are illegal and recover to S0.
  localparam logic [STATE_W-1:0] S0 = 3'b000;  // idle / no prefix
  localparam logic [STATE_W-1:0] S1 = 3'b001;  // "1" seen
  localparam logic [STATE_W-1:0] S2 = 3'b010;  // "10" seen
  localparam logic [STATE_W-1:0] S3 = 3'b011;  // "100" seen

endpackage : fsm_mealy_pkg

// File: rtl/fsm_mealy.sv
// -----------------------------------------------------------------------------
// fsm_mealy
// Mealy-type serial detector for the bit pattern 1-0-0-1. The input a is
// sampled on every rising clock edge; z is asserted combinationally while the
// FSM sits in S3 ("100" seen) and a is 1, i.e. in the same cycle the final
// pattern bit is presented. The state register is exported on y for debug.
//
// Ports:
//   clk     in   1  rising-edge system clock
//   resetn  in   1  asynchronous active-low reset (forces S0)
//   a       in   1  serial sensor bit
//   y       out  3  current state register
//   z       out  1  detect output, combinational from state and a
//
// Build option:
//   FSM_MEALY_OVERLAP_EN  defined   -> overlapping detection: the terminating 1
//                                      of a match also starts the next match
//                                      (S3, a=1 -> S1).
//                         undefined -> non-overlapping detection
//                                      (S3, a=1 -> S0).
// -----------------------------------------------------------------------------
module fsm_mealy
  import fsm_mealy_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               a,
  output logic [STATE_W-1:0] y,
  output logic               z
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  // Next-state and Mealy output logic.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so that
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    state_d = S0;
    z       = 1'b0;
    unique case (state_q)
      S0: state_d = a ? S1 : S0;
      S1: state_d = a ? S1 : S2;
      S2: state_d = a ? S1 : S3;
      S3: begin
        z = a;
`ifdef FSM_MEALY_OVERLAP_EN
        // The terminating 1 doubles as the first bit of the next match.
        state_d = a ? S1 : S0;
`else
        // The terminating 1 is consumed by this match and not reused.
        state_d = S0;
`endif
      end
      // Illegal codes fall back to S0 with z held low.
      default: state_d = S0;
    endcase
  end

  // State register: the only storage in the design.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples values from before the edge, independent of statement order.
    if (!resetn) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign y = state_q;

endmodule : fsm_mealy

// File: tb/tb_fsm_mealy.sv
// -----------------------------------------------------------------------------
// tb_fsm_mealy
// Self-checking bench for fsm_mealy. Stimulus tasks drive a, update a
// reference model that reasons about the recent input history (suffix of the
// bits seen since the last restart), and push the expected (y, z) pair into a
// scoreboard queue. A separate monitor pops one entry per cycle and compares
// it against the DUT shortly before the consuming clock edge. Reset, Mealy
// mid-cycle behaviour and illegal-state recovery use direct checks.
// Honors FSM_MEALY_OVERLAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fsm_mealy;
  import fsm_mealy_pkg::*;

  logic               clk = 1'b0;
  logic               resetn;
  logic               a;
  logic [STATE_W-1:0] y;
  logic               z;

  fsm_mealy dut (
    .clk    (clk),
    .resetn (resetn),
    .a      (a),
    .y      (y),
    .z      (z)
  );

  // Period 10, first rising edge at t=5.
  always #5 clk = ~clk;

`ifdef FSM_MEALY_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  typedef struct packed {
    logic [STATE_W-1:0] y;
    logic               z;
  } exp_t;

  int   errors     = 0;
  int   checks     = 0;
  int   dut_pulses = 0;
  exp_t exp_q[$];
  bit   hist[$];     // input bits consumed since the last restart

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Progress toward 1001 = length of the longest suffix of the history that
  // is a prefix of "100".
  function automatic logic [STATE_W-1:0] model_progress();
    int n = hist.size();
    if (n >= 3 && hist[n-3] == 1'b1 && hist[n-2] == 1'b0 && hist[n-1] == 1'b0)
      return 3'd3;
    if (n >= 2 && hist[n-2] == 1'b1 && hist[n-1] == 1'b0)
      return 3'd2;
    if (n >= 1 && hist[n-1] == 1'b1)
      return 3'd1;
    return 3'd0;
  endfunction

  // Consume one bit: expected y is the progress before the bit, z fires when
  // the bit completes 1001. A non-overlapping match discards all history.
  task automatic model_step(input bit v, output exp_t e);
    e.y = model_progress();
    e.z = (e.y == 3'd3) && v;
    hist.push_back(v);
    if (hist.size() > 8) void'(hist.pop_front());
    if (e.z && !OVERLAP) hist.delete();
  endtask

  // Drive one bit 3 time units before the next rising edge.
  task automatic apply(input bit v);
    exp_t e;
    @(posedge clk);
    #7;
    a = v;
    model_step(v, e);
    exp_q.push_back(e);
  endtask

  // Async reset pulse between edges; the edge after release consumes a=0.
  task automatic async_reset();
    @(posedge clk);
    #4;
    resetn = 1'b0;
    a      = 1'b0;
    hist.delete();
    #1;
    check("areset_y", y, S0);
    check("areset_z", z, 1'b0);
    #2;
    resetn = 1'b1;
    hist.push_back(1'b0);
  endtask

  // Monitor: samples 2 units before each rising edge, after the driver.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #8;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_y", y, e.y);
        check("sb_z", z, e.z);
        if (z === 1'b1) dut_pulses++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit   prim[15] = '{1,1,0,0,1,0,0,1,0,1,1,0,0,1,0};
    bit   ovl[7]   = '{1,0,0,1,0,0,1};
    exp_t dummy;

    // 1. Reset held with a=1 across the edge at t=5.
    resetn = 1'b0;
    a      = 1'b1;
    #2;
    check("rst_y_t2", y, S0);
    check("rst_z_t2", z, 1'b0);
    #6;
    check("rst_y_t8", y, S0);
    check("rst_z_t8", z, 1'b0);
    #4;
    resetn = 1'b1;                     // t=12
    #2;
    check("rel_hold_y", y, S0);        // t=14, no edge yet
    #2;
    check("rel_first_edge_y", y, S1);  // t=16, edge at 15 consumed a=1
    hist.push_back(1'b1);              // edge at 15
    hist.push_back(1'b1);              // edge at 25 also sees a=1

    // 2. Primary sequence.
    foreach (prim[i]) apply(prim[i]);

    // 3. Async reset while in S3.
    async_reset();
    apply(1'b1);
    apply(1'b0);
    apply(1'b0);
    @(posedge clk);
    #1;
    check("mid_s3_y", y, S3);
    #1;
    a = 1'b1;
    #1;
    check("mid_s3_z", z, 1'b1);
    resetn = 1'b0;
    #1;
    check("mid_rst_y", y, S0);
    check("mid_rst_z", z, 1'b0);
    #2;
    resetn = 1'b1;
    a      = 1'b0;
    hist.delete();
    hist.push_back(1'b0);
    apply(1'b1);                       // scoreboard expects y=S0, z=0

    // 4. Overlap behaviour on 1001001.
    async_reset();
    dut_pulses = 0;
    foreach (ovl[i]) apply(ovl[i]);
    #2;
    check("overlap_pulses", dut_pulses, OVERLAP ? 2 : 1);

    // 5. Mealy timing: z tracks a inside one cycle while in S3.
    async_reset();
    apply(1'b1);
    apply(1'b0);
    apply(1'b0);
    @(posedge clk);
    #1;
    a = 1'b0;
    #1;
    check("mealy_y", y, S3);
    check("mealy_z_a0", z, 1'b0);
    a = 1'b1;
    #1;
    check("mealy_z_a1", z, 1'b1);
    a = 1'b0;
    #1;
    check("mealy_z_back0", z, 1'b0);
    #1;
    a = 1'b1;                          // value present at the edge
    model_step(1'b1, dummy);
    apply(1'b0);                       // scoreboard checks y after that edge

    // 6. Illegal state 101 recovers to S0 with z held low.
    async_reset();
    @(posedge clk);
    #1;
    force dut.state_q = 3'b101;
    #1;
    check("illegal_y", y, 3'b101);
    a = 1'b0;
    #1;
    check("illegal_z_a0", z, 1'b0);
    a = 1'b1;
    #1;
    check("illegal_z_a1", z, 1'b0);
    a = 1'b0;
    #1;
    release dut.state_q;
    @(posedge clk);
    #1;
    check("illegal_recover_y", y, S0);
    hist.delete();
    hist.push_back(1'b0);

    // Randomized stream against the model.
    repeat (300) apply(1'($urandom_range(0, 1)));
    #2;
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fsm_mealy
